// File: rtl/adder_result_accumulator.sv
// Clocked sink for the two-bit adder: sums a fixed-length burst of 3-bit results
// and hands the total downstream. Define ACC_SATURATE_EN to clamp instead of wrap.
module adder_result_accumulator #(
    parameter int ACC_WIDTH = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 carry_out,
    input  logic                 sum1,
    input  logic                 sum0,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 overflow,
    output logic                 busy
);

    localparam int SUM_W = ACC_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [CNT_WIDTH-1:0]   r_count;
    logic                   r_overflow;
    logic                   r_out_valid;
    logic                   r_busy;

    logic [2:0]             w_sample;
    logic [ACC_WIDTH-1:0]   w_sample_ext;
    logic [SUM_W-1:0]       w_sum;
    logic [ACC_WIDTH-1:0]   w_acc_add;
    logic [CNT_WIDTH-1:0]   w_count_inc;
    logic                   w_last;
    logic                   w_accept;
    logic                   w_in_ready;
    logic                   w_out_valid_nxt;
    logic                   w_busy_nxt;

    assign w_sample     = {carry_out, sum1, sum0};
    assign w_sample_ext = ACC_WIDTH'(w_sample);
    assign w_sum        = SUM_W'(r_acc) + SUM_W'(w_sample);
    // r_count is zero in IDLE, so the same increment serves the first sample.
    assign w_count_inc  = r_count + CNT_WIDTH'(1'b1);
    assign w_last       = (w_count_inc == CNT_WIDTH'(BURST_LEN));
    assign w_accept     = in_valid && w_in_ready;

    // Wrap or clamp the running sum on overflow.
    always_comb begin
        w_acc_add = w_sum[ACC_WIDTH-1:0];
`ifdef ACC_SATURATE_EN
        if (w_sum[ACC_WIDTH]) begin
            w_acc_add = {ACC_WIDTH{1'b1}};
        end else begin
            w_acc_add = w_sum[ACC_WIDTH-1:0];
        end
`else
        w_acc_add = w_sum[ACC_WIDTH-1:0];
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clear overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_accept) begin
                        w_state_nxt = w_last ? S_DONE : S_ACCUM;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output decode: in_ready is combinational, valid/busy are prepared for registering.
    always_comb begin
        w_in_ready      = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        case (r_state)
            S_IDLE, S_ACCUM: w_in_ready = 1'b1;
            S_DONE:          w_in_ready = 1'b0;
            default:         w_in_ready = 1'b0;
        endcase
        case (w_state_nxt)
            S_ACCUM: w_busy_nxt      = 1'b1;
            S_DONE:  w_out_valid_nxt = 1'b1;
            default: begin
                w_busy_nxt      = 1'b0;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    // Registered status flags, aligned with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Accumulator, sample counter and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= {ACC_WIDTH{1'b0}};
            r_count    <= {CNT_WIDTH{1'b0}};
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_acc      <= {ACC_WIDTH{1'b0}};
            r_count    <= {CNT_WIDTH{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc      <= w_sample_ext;
                        r_count    <= w_count_inc;
                        r_overflow <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= w_acc_add;
                        r_count <= w_count_inc;
                        if (w_sum[ACC_WIDTH]) begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // overflow stays visible until the next burst starts
                    if (out_ready) begin
                        r_acc   <= {ACC_WIDTH{1'b0}};
                        r_count <= {CNT_WIDTH{1'b0}};
                    end
                end
                default: begin
                    r_acc      <= {ACC_WIDTH{1'b0}};
                    r_count    <= {CNT_WIDTH{1'b0}};
                    r_overflow <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign acc_out   = r_acc;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Directed bench: default-parameter instance for burst/gap/backpressure/clear/reset,
// a narrow instance (ACC_WIDTH=3, BURST_LEN=2) for overflow.
module tb_adder_result_accumulator;

    logic       clk;
    logic       rst_n;
    logic       carry_out, sum1, sum0;
    logic       clear;
    logic       out_ready;
    logic       in_valid_a, in_valid_b;
    logic       in_ready_a, in_ready_b;
    logic       out_valid_a, out_valid_b;
    logic [7:0] acc_out_a;
    logic [2:0] acc_out_b;
    logic       overflow_a, overflow_b;
    logic       busy_a, busy_b;

    int checks   = 0;
    int failures = 0;

    adder_result_accumulator #(.ACC_WIDTH(8), .BURST_LEN(4), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .carry_out(carry_out), .sum1(sum1), .sum0(sum0), .clear(clear),
        .out_valid(out_valid_a), .out_ready(out_ready), .acc_out(acc_out_a),
        .overflow(overflow_a), .busy(busy_a)
    );

    adder_result_accumulator #(.ACC_WIDTH(3), .BURST_LEN(2), .CNT_WIDTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .carry_out(carry_out), .sum1(sum1), .sum0(sum0), .clear(clear),
        .out_valid(out_valid_b), .out_ready(out_ready), .acc_out(acc_out_b),
        .overflow(overflow_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [2:0] v);
        {carry_out, sum1, sum0} = v;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [2:0] v);
        {carry_out, sum1, sum0} = v;
        in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        {carry_out, sum1, sum0} = 3'd0;
        #3;
        chk("rst_in_ready",  32'(in_ready_a),  32'd1);
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_acc_out",   32'(acc_out_a),   32'd0);
        chk("rst_overflow",  32'(overflow_a),  32'd0);
        chk("rst_busy",      32'(busy_a),      32'd0);
        #9 rst_n = 1'b1;

        // basic burst 3,6,1,2 with out_ready=1
        out_ready = 1'b1;
        send_a(3'd3);
        chk("basic_busy_first", 32'(busy_a), 32'd1);
        send_a(3'd6);
        send_a(3'd1);
        chk("basic_no_valid_early", 32'(out_valid_a), 32'd0);
        send_a(3'd2);
        chk("basic_out_valid", 32'(out_valid_a), 32'd1);
        chk("basic_acc_12",    32'(acc_out_a),   32'd12);
        chk("basic_ovf_0",     32'(overflow_a),  32'd0);
        chk("basic_in_ready0", 32'(in_ready_a),  32'd0);
        chk("basic_busy_done", 32'(busy_a),      32'd0);
        tick();
        chk("basic_idle_valid", 32'(out_valid_a), 32'd0);
        chk("basic_idle_ready", 32'(in_ready_a),  32'd1);
        chk("basic_idle_acc",   32'(acc_out_a),   32'd0);

        // gaps: 5,0,4,6 with 2-cycle holes
        out_ready = 1'b0;
        send_a(3'd5);
        tick(); tick();
        chk("gap_busy_hole", 32'(busy_a), 32'd1);
        chk("gap_acc_held",  32'(acc_out_a), 32'd5);
        send_a(3'd0);
        tick(); tick();
        send_a(3'd4);
        tick(); tick();
        chk("gap_busy_late", 32'(busy_a), 32'd1);
        send_a(3'd6);
        chk("gap_out_valid", 32'(out_valid_a), 32'd1);
        chk("gap_acc_15",    32'(acc_out_a),   32'd15);
        chk("gap_busy_done", 32'(busy_a),      32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // backpressure: total 12, out_ready low for 5 cycles with samples offered
        send_a(3'd3); send_a(3'd3); send_a(3'd3); send_a(3'd3);
        {carry_out, sum1, sum0} = 3'd5;
        in_valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready0", 32'(in_ready_a),  32'd0);
            chk("bp_acc_held",  32'(acc_out_a),   32'd12);
            chk("bp_valid_hi",  32'(out_valid_a), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_valid_drop", 32'(out_valid_a), 32'd0);
        chk("bp_ready_back", 32'(in_ready_a),  32'd1);
        tick();
        in_valid_a = 1'b0;
        chk("bp_new_busy", 32'(busy_a),    32'd1);
        chk("bp_new_acc",  32'(acc_out_a), 32'd5);
        send_a(3'd0); send_a(3'd0); send_a(3'd0);
        chk("bp_new_total", 32'(acc_out_a), 32'd5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // overflow on the narrow instance: 6+6 in 3 bits
        send_b(3'd6);
        chk("ovf_first_ovf", 32'(overflow_b), 32'd0);
        send_b(3'd6);
        chk("ovf_valid", 32'(out_valid_b), 32'd1);
`ifdef ACC_SATURATE_EN
        chk("ovf_acc", 32'(acc_out_b), 32'd7);
`else
        chk("ovf_acc", 32'(acc_out_b), 32'd4);
`endif
        chk("ovf_flag", 32'(overflow_b), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ovf_sticky_after_hs", 32'(overflow_b), 32'd1);
        send_b(3'd1);
        chk("ovf_cleared_new", 32'(overflow_b), 32'd0);
        send_b(3'd1);
        chk("ovf_small_acc", 32'(acc_out_b), 32'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // clear mid-burst drops the same-cycle sample
        send_a(3'd6); send_a(3'd6);
        chk("clr_pre_acc", 32'(acc_out_a), 32'd12);
        {carry_out, sum1, sum0} = 3'd3;
        in_valid_a = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid_a = 1'b0;
        chk("clr_acc",   32'(acc_out_a),  32'd0);
        chk("clr_busy",  32'(busy_a),     32'd0);
        chk("clr_ready", 32'(in_ready_a), 32'd1);
        send_a(3'd1); send_a(3'd1); send_a(3'd1); send_a(3'd1);
        chk("clr_new_valid", 32'(out_valid_a), 32'd1);
        chk("clr_new_acc",   32'(acc_out_a),   32'd4);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_done_valid", 32'(out_valid_a), 32'd0);
        chk("clr_done_acc",   32'(acc_out_a),   32'd0);

        // asynchronous reset mid-burst
        send_a(3'd2); send_a(3'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",  32'(busy_a),      32'd0);
        chk("arst_acc",   32'(acc_out_a),   32'd0);
        chk("arst_ready", 32'(in_ready_a),  32'd1);
        chk("arst_valid", 32'(out_valid_a), 32'd0);
        #1 rst_n = 1'b1;
        send_a(3'd2); send_a(3'd2); send_a(3'd2); send_a(3'd2);
        chk("arst_new_valid", 32'(out_valid_a), 32'd1);
        chk("arst_new_acc",   32'(acc_out_a),   32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_result_accumulator.md
Name: adder_result_accumulator

Overview:
- Downstream consumer of the two-bit ripple adder stage (TwoBitAdder).
- Captures the adder's 3-bit result (carry_out, sum1, sum0) under a valid/ready handshake and accumulates a fixed-length burst of results into a wide register.
- Presents the burst total to the next stage under a second valid/ready handshake.
- Gives the adder test benches a clocked, observable sink for checking settled gate-delay outputs.

Parameters:
- ACC_WIDTH, 8, accumulator and acc_out width in bits; legal range 3..32.
- BURST_LEN, 4, number of accepted samples per burst; legal range 1..255.
- CNT_WIDTH, 8, width of the internal sample counter; must satisfy 2^CNT_WIDTH > BURST_LEN.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  adder result is settled and offered.
- in_ready  output  1  block can accept a sample this cycle.
- carry_out  input  1  adder carry; weight 4.
- sum1  input  1  adder sum bit 1; weight 2.
- sum0  input  1  adder sum bit 0; weight 1.
- clear  input  1  synchronous abort of the current burst.
- out_valid  output  1  burst total is available.
- out_ready  input  1  downstream accepts the total.
- acc_out  output  ACC_WIDTH  burst total; stable while out_valid=1.
- overflow  output  1  the burst total exceeded the acc_out range.
- busy  output  1  a burst is in progress (state ACCUM).

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, acc=0, count=0, out_valid=0, in_ready=1, acc_out=0, overflow=0, busy=0.
- Sample value: sample = {carry_out,sum1,sum0}, zero-extended to ACC_WIDTH. The legal range is 0..6. Value 7 is accepted and added as 7; it is not checked.
- Accept condition: a sample is accepted when in_valid && in_ready at a rising clk edge.
- in_ready is combinational: 1 in IDLE and ACCUM, 0 in DONE.
- States:
  - IDLE
    - On accept: acc=sample, count=1, overflow=0.
    - Next state is ACCUM, or DONE if BURST_LEN==1.
  - ACCUM (busy=1)
    - On accept: acc=acc+sample modulo 2^ACC_WIDTH, count=count+1.
    - If the true sum exceeds 2^ACC_WIDTH-1, set overflow (sticky for the burst).
    - When the new count equals BURST_LEN, go to DONE.
    - No accept: hold all state. Gaps of any length are allowed.
  - DONE
    - out_valid=1; acc_out and overflow are held.
    - On out_ready=1: next cycle state=IDLE, out_valid=0, acc=0, count=0. overflow stays visible until the next burst's first accept.
    - If out_ready stays 0, DONE is held indefinitely with no samples taken.
- Latency:
  - out_valid rises on the edge after the accept that completes the burst.
  - The earliest new-burst accept is the cycle after the out_ready handshake. There is no same-cycle DONE-to-accept bypass.
- clear:
  - Synchronous; priority below reset, above everything else.
  - Effect: state=IDLE, acc=0, count=0, overflow=0, out_valid=0.
  - A sample offered in the same cycle as clear is dropped, even though in_ready=1.
  - clear asserted in DONE discards the unconsumed total.
- Reset mid-burst: all state returns immediately to reset values, and partial sums are lost.
- acc_out drives the acc register directly. It is meaningful only while out_valid=1.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: an addition whose true sum exceeds 2^ACC_WIDTH-1 clamps acc to 2^ACC_WIDTH-1 and sets overflow. Later samples in the burst keep acc at the maximum.
- Undefined (default): acc wraps modulo 2^ACC_WIDTH and overflow is set as above.

Test Plan:
- Basic burst (defaults): samples 3,6,1,2 on consecutive cycles with out_ready=1 → out_valid=1 one cycle after the 4th accept, acc_out=12, overflow=0, back in IDLE the next cycle.
- Input gaps: samples 5,0,4,6 separated by 2-cycle in_valid=0 gaps → acc_out=15; busy=1 from the first accept until DONE.
- Backpressure: complete a burst totalling 12, hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0 and acc_out=12 held throughout; out_ready=1 → out_valid drops the next cycle, and the next sample is accepted as a new burst.
- Overflow (ACC_WIDTH=3, BURST_LEN=2): samples 6,6 → acc_out=4, overflow=1. With ACC_SATURATE_EN defined → acc_out=7, overflow=1.
- clear and reset: accept 6,6 then assert clear together with sample 3 → sample dropped, IDLE, acc=0; a new burst of 1,1,1,1 gives 4. Separately, pulse rst_n low asynchronously mid-burst → outputs take reset values at once; a subsequent burst of 2,2,2,2 gives 8.
